// File: rtl/udma_ctrl_seq_if.sv
// Configuration and event bus between the uDMA cfg decoder (master) and udma_ctrl_seq (slave).
// The fixed-width read/write strobes and the event strobe travel together here.
interface udma_ctrl_seq_if;
  logic [31:0] cfg_data_i;
  logic [4:0]  cfg_addr_i;
  logic        cfg_valid_i;
  logic        cfg_rwn_i;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;
  logic        event_valid_i;
  logic [7:0]  event_data_i;
  logic        event_ready_o;

  modport master (
    output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i, event_valid_i, event_data_i,
    input  cfg_data_o, cfg_ready_o, event_ready_o
  );

  modport slave (
    input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i, event_valid_i, event_data_i,
    output cfg_data_o, cfg_ready_o, event_ready_o
  );
endinterface

// File: rtl/udma_ctrl_seq.sv
// uDMA top-level control: per-peripheral clock gate / reset registers, event comparators,
// L2 prefix, and a gate -> reset pulse -> ungate soft-reset sequencer.
module udma_ctrl_seq #(
  parameter int L2_AWIDTH_NOAL   = 15,
  parameter int N_PERIPHS        = 6,
  parameter int N_EVT            = 4,
  parameter int RST_PULSE_CYCLES = 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  udma_ctrl_seq_if.slave              bus,
  output logic [N_PERIPHS-1:0]        rst_value_o,
  output logic [N_PERIPHS-1:0]        cg_value_o,
  output logic                        cg_core_o,
  output logic [N_EVT-1:0]            event_o,
  output logic [31-L2_AWIDTH_NOAL:0]  l2_dest_o
);

  localparam int          P        = 32 - L2_AWIDTH_NOAL;
  localparam logic [7:0]  CNT_INIT = 8'(RST_PULSE_CYCLES - 1);

  localparam logic [4:0] A_CG        = 5'h00;
  localparam logic [4:0] A_CFG_EVT   = 5'h01;
  localparam logic [4:0] A_RST       = 5'h02;
  localparam logic [4:0] A_RST_PULSE = 5'h03;
  localparam logic [4:0] A_L2_DEST   = 5'h04;
  localparam logic [4:0] A_STATUS    = 5'h05;
  localparam logic [4:0] A_EVT_EN    = 5'h06;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_RST,
    S_UNGATE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [N_PERIPHS-1:0]   r_cg;
  logic [N_PERIPHS-1:0]   r_rst;
  logic [31:0]            r_evt;
  logic [N_EVT-1:0]       r_evt_en;
  logic [P-1:0]           r_l2;
  logic [N_PERIPHS-1:0]   r_pend;
  logic [N_PERIPHS-1:0]   r_act;
  logic [7:0]             r_cnt;

  logic                   w_wr;
  logic                   w_rd;
  logic                   w_take;
  logic [N_PERIPHS-1:0]   w_pend_nxt;
  logic [N_PERIPHS-1:0]   w_act_nxt;
  logic [7:0]             w_cnt_nxt;
  logic [N_PERIPHS-1:0]   w_pulse_req;
  logic [N_PERIPHS-1:0]   w_gate_force;
  logic [N_PERIPHS-1:0]   w_rst_force;
  logic [31:0]            w_status;
  logic [31:0]            w_rdata;
  logic                   w_busy;

  assign w_wr = bus.cfg_valid_i & ~bus.cfg_rwn_i;
  assign w_rd = bus.cfg_valid_i &  bus.cfg_rwn_i;

  assign w_pulse_req = (w_wr && bus.cfg_addr_i == A_RST_PULSE) ?
                       bus.cfg_data_i[N_PERIPHS-1:0] : '0;

  // Sequencer next state
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_act_nxt   = r_act;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_pend != '0) begin
          w_take      = 1'b1;
          w_act_nxt   = r_pend;
          w_state_nxt = S_GATE;
        end
      end
      S_GATE: begin
        w_cnt_nxt   = CNT_INIT;
        w_state_nxt = S_RST;
      end
      S_RST: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_UNGATE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_UNGATE: begin
        w_act_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bits requested in the same cycle the sequencer takes pending stay queued.
  assign w_pend_nxt = (w_take ? '0 : r_pend) | w_pulse_req;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cg     <= '0;
      r_rst    <= '0;
      r_evt    <= '0;
      r_evt_en <= '0;
      r_l2     <= '0;
      r_pend   <= '0;
      r_act    <= '0;
      r_cnt    <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_act  <= w_act_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_wr) begin
        case (bus.cfg_addr_i)
          A_CG:      r_cg     <= bus.cfg_data_i[N_PERIPHS-1:0];
          A_CFG_EVT: r_evt    <= bus.cfg_data_i;
          A_RST:     r_rst    <= bus.cfg_data_i[N_PERIPHS-1:0];
          A_L2_DEST: r_l2     <= bus.cfg_data_i[P-1:0];
          A_EVT_EN:  r_evt_en <= bus.cfg_data_i[N_EVT-1:0];
          default: ;
        endcase
      end
    end
  end

  assign w_busy       = (r_state != S_IDLE);
  assign w_gate_force = w_busy ? r_act : '0;
  assign w_rst_force  = (r_state == S_RST) ? r_act : '0;

  assign cg_value_o  = r_cg & ~w_gate_force;
  assign rst_value_o = r_rst | w_rst_force;
  assign cg_core_o   = |cg_value_o;
  assign l2_dest_o   = r_l2;

  always_comb begin
    event_o = '0;
    for (int i = 0; i < N_EVT; i++) begin
      event_o[i] = bus.event_valid_i & r_evt_en[i] & (bus.event_data_i == r_evt[8*i +: 8]);
    end
  end

  always_comb begin
    w_status                    = '0;
    w_status[31]                = w_busy;
    w_status[16 +: N_PERIPHS]   = r_pend;
    w_status[N_PERIPHS-1:0]     = r_act;
  end

  // RST_PULSE is write-only and reads back as 0 via the default arm.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (bus.cfg_addr_i)
        A_CG:      w_rdata = 32'(r_cg);
        A_CFG_EVT: w_rdata = r_evt;
        A_RST:     w_rdata = 32'(r_rst);
        A_L2_DEST: w_rdata = 32'(r_l2);
        A_STATUS:  w_rdata = w_status;
        A_EVT_EN:  w_rdata = 32'(r_evt_en);
        default:   w_rdata = '0;
      endcase
    end
  end

  assign bus.cfg_data_o    = w_rdata;
  assign bus.cfg_ready_o   = 1'b1;
  assign bus.event_ready_o = 1'b1;

endmodule
